// File: rtl/mul_acc_pkg.sv
// Shared widths and output-state encoding for the windowed multiply-add accumulator.
package mul_acc_pkg;

    localparam int MUL_DATA_W = 16;
    localparam int MUL_ACC_W  = 24;
    localparam int MUL_LEN    = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/acc_window_counter.sv
// Sample-in-window counter; flags the sample position that closes a window.
module acc_window_counter
    import mul_acc_pkg::*;
#(
    parameter int LEN = MUL_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            if (last) cnt <= '0;
            else      cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/mul_accumulator.sv
// Windowed accumulator behind the multiply-add stage; never stalls its input.
// Define MUL_ACC_SAT_EN to clamp on overflow instead of wrapping.
//
//   state     | meaning
//   OUT_EMPTY | no window sum pending, out_valid low
//   OUT_FULL  | obuf holds an unaccepted sum, out_valid high
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W,
    parameter int ACC_W  = MUL_ACC_W,
    parameter int LEN    = MUL_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              drop,
    output logic              ovf
);

    out_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] obuf;
    logic             carry;
    logic             accept;
    logic             last;
    logic             complete;
    logic             load;
    logic             drop_d;

    assign accept   = in_valid & ~clear;
    assign complete = accept & last;

    acc_window_counter #(.LEN(LEN)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (accept),
        .last  (last)
    );

    assign sum_wide = {1'b0, acc} + {1'b0, ACC_W'(in_data)};
    assign carry    = sum_wide[ACC_W];

`ifdef MUL_ACC_SAT_EN
    // A clamped acc re-carries on any nonzero addend, so it stays clamped.
    assign acc_next = carry ? '1 : sum_wide[ACC_W-1:0];
`else
    assign acc_next = sum_wide[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (in_valid) begin
                acc <= last ? '0 : acc_next;
                if (carry) ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                // Completion coinciding with a handshake replaces the sum, no drop.
                if (complete) begin
                    if (out_ready) load   = 1'b1;
                    else           drop_d = 1'b1;
                end else if (out_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            obuf    <= '0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            drop    <= drop_d;
            if (load) obuf <= acc_next;
        end
    end

    assign out_valid = (state_q == OUT_FULL);
    assign out_data  = obuf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed self-checking bench for mul_accumulator (default and ACC_W=16 instances).
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        drop;
    logic        ovf;

    logic        v16;
    logic [15:0] d16;
    logic        c16;
    logic        ov16;
    logic        r16;
    logic [15:0] od16;
    logic        dr16;
    logic        ovf16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop      (drop),
        .ovf       (ovf)
    );

    mul_accumulator #(.DATA_W(16), .ACC_W(16), .LEN(8)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .in_data   (d16),
        .clear     (c16),
        .out_valid (ov16),
        .out_ready (r16),
        .out_data  (od16),
        .drop      (dr16),
        .ovf       (ovf16)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); out_ready = 1'b0;
        v16 = 1'b0; d16 = '0; c16 = 1'b0; r16 = 1'b1;
        cyc(); cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_cmp++; if (out_data !== 24'd0) begin n_err++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop got %0b exp 0", drop); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
        n_cmp++; if (ovf16 !== 1'b0) begin n_err++; $display("FAIL reset_ovf16 got %0b exp 0", ovf16); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'd100;
            cyc();
            n_cmp++; if (out_valid !== (i == 8)) begin n_err++; $display("FAIL basic_valid s%0d got %0b exp %0b", i, out_valid, (i == 8)); end
            n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL basic_drop s%0d got %0b exp 0", i, drop); end
        end
        n_cmp++; if (out_data !== 24'd800) begin n_err++; $display("FAIL basic_data got %0d exp 800", out_data); end
        idle();
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed got %0b exp 0", out_valid); end
    endtask

    task automatic test_drop();
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 16'd1;
            cyc();
            n_cmp++; if (out_valid !== (i >= 8)) begin n_err++; $display("FAIL drop_valid s%0d got %0b exp %0b", i, out_valid, (i >= 8)); end
            if (i >= 8) begin
                n_cmp++; if (out_data !== 24'd8) begin n_err++; $display("FAIL drop_hold s%0d got %0d exp 8", i, out_data); end
            end
            n_cmp++; if (drop !== (i == 16)) begin n_err++; $display("FAIL drop_pulse s%0d got %0b exp %0b", i, drop, (i == 16)); end
        end
        idle();
        cyc();
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL drop_one_cycle got %0b exp 0", drop); end
        n_cmp++; if (out_data !== 24'd8) begin n_err++; $display("FAIL drop_after_data got %0d exp 8", out_data); end
        out_ready = 1'b1;
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_handshake got %0b exp 0", out_valid); end
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_single_hs got %0b exp 0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'd5;
            cyc();
        end
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd5;
        cyc();
        clear = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'd2;
            cyc();
            n_cmp++; if (out_valid !== (i == 8)) begin n_err++; $display("FAIL clear_valid s%0d got %0b exp %0b", i, out_valid, (i == 8)); end
        end
        n_cmp++; if (out_data !== 24'd16) begin n_err++; $display("FAIL clear_data got %0d exp 16", out_data); end
        idle();
        cyc();
    endtask

    task automatic test_ovf();
        logic [15:0] exp_sum;
`ifdef MUL_ACC_SAT_EN
        exp_sum = 16'hFFFF;
`else
        exp_sum = 16'hFFF8;
`endif
        r16 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v16 = 1'b1; d16 = 16'hFFFF;
            cyc();
        end
        v16 = 1'b0; d16 = '0;
        n_cmp++; if (ov16 !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %0b exp 1", ov16); end
        n_cmp++; if (od16 !== exp_sum) begin n_err++; $display("FAIL ovf_sum got %h exp %h", od16, exp_sum); end
        n_cmp++; if (ovf16 !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b exp 1", ovf16); end
        cyc(); cyc();
        n_cmp++; if (ovf16 !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b exp 1", ovf16); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_wide_dut got %0b exp 0", ovf); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'd4;
            cyc();
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 16'd6;
            cyc();
        end
        n_cmp++; if (out_data !== 24'd32) begin n_err++; $display("FAIL b2b_first got %0d exp 32", out_data); end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd6;
        cyc();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %0b exp 1", out_valid); end
        n_cmp++; if (out_data !== 24'd48) begin n_err++; $display("FAIL b2b_data got %0d exp 48", out_data); end
        idle();
        cyc();
        n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL b2b_drop got %0b exp 0", drop); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_consumed got %0b exp 0", out_valid); end
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 16'd7;
            cyc();
            n_cmp++; if (out_valid !== (i == 8 || i == 16)) begin n_err++; $display("FAIL stream_valid s%0d got %0b", i, out_valid); end
            n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL stream_drop s%0d got %0b exp 0", i, drop); end
            if (i == 8 || i == 16) begin
                n_cmp++; if (out_data !== 24'd56) begin n_err++; $display("FAIL stream_data s%0d got %0d exp 56", i, out_data); end
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'd9;
            cyc();
        end
        idle();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || drop !== 1'b0) begin n_err++; $display("FAIL rstmid_partial valid %0b drop %0b exp 0 0", out_valid, drop); end
        n_cmp++; if (ovf16 !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf16 got %0b exp 0", ovf16); end
        #1 rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'd1;
            cyc();
        end
        idle();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_prefull got %0b exp 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b exp 0", out_valid); end
        n_cmp++; if (out_data !== 24'd0) begin n_err++; $display("FAIL rstmid_data got %0d exp 0", out_data); end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'd3;
            cyc();
            n_cmp++; if (out_valid !== (i == 8)) begin n_err++; $display("FAIL rstmid_win s%0d got %0b exp %0b", i, out_valid, (i == 8)); end
        end
        n_cmp++; if (out_data !== 24'd24) begin n_err++; $display("FAIL rstmid_sum got %0d exp 24", out_data); end
        idle();
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_clear();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
